demux1hot_stream: RTL and testbench
===================================

# demux1hot_stream

One-hot stream demultiplexer with a default (sink) output and a single-entry registered output stage. It takes a valid/ready input stream with a per-beat one-hot select and delivers each beat to exactly one of OUTPUTS consumers. Beats whose select is not exactly one-hot (all-zero or multi-hot) go to the default port and are counted. It is the distribution-side counterpart of the one-hot mux: it fans a stream out where the mux gathers one in.

## Interface
- OUTPUTS, 2, number of routed output ports (>= 2)
- WIDTH, 1, data width in bits (>= 1)
- CNT_WIDTH, 8, width of the default-route beat counter (>= 1)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  WIDTH  input payload
- in_sel  input  OUTPUTS  one-hot destination select, sampled with the beat
- out_valid  output  OUTPUTS  per-port valid; at most one bit set
- out_ready  input  OUTPUTS  per-port ready
- dflt_valid  output  1  default-port valid
- dflt_ready  input  1  default-port ready
- out_data  output  WIDTH  registered payload, shared by all routed ports and the default port
- dflt_cnt  output  CNT_WIDTH  saturating count of beats accepted to the default port
- cnt_clr  input  1  synchronous clear of dflt_cnt

## Operation
- State: buf_valid (1 b), buf_data (WIDTH), route (OUTPUTS+1 bits, one-hot; bit OUTPUTS = default), dflt_cnt.
- Route decode at accept: if in_sel has exactly one bit set, route = {1'b0, in_sel}; otherwise (zero or >=2 bits set), route = {1'b1, 0}.
- out_valid[i] = buf_valid & route[i]; dflt_valid = buf_valid & route[OUTPUTS].
- out_data = buf_data and is held stable while buf_valid is set and not drained.
- drained = buf_valid & |(route & {dflt_ready, out_ready}). Ready on non-selected ports is ignored.
- in_ready = ~rst & (~buf_valid | drained). Full throughput: a new beat is accepted in the same cycle the held beat drains.
- Accept: buf_valid <= 1, buf_data <= in_data, route <= decoded route.
- Drain without accept: buf_valid <= 0. buf_data and route hold their last values.
- Neither: state holds. Valid never drops before the handshake, per the valid/ready rule.
- dflt_cnt: increments by 1 on each accepted beat whose decoded route is default. It saturates at 2^CNT_WIDTH-1. If cnt_clr is high in a cycle, dflt_cnt becomes 0, even when an increment occurs in the same cycle.
- in_sel and in_data are don't-care when in_valid is low.

## Timing
- Reset (asynchronous assert, synchronous effect on release edge): buf_valid=0, buf_data=0, route=0, dflt_cnt=0. As a result out_valid=0, dflt_valid=0, out_data=0, and in_ready=0 while rst is high.
- The first cycle after rst deasserts has in_ready=1.
- Latency: a beat accepted at edge N is visible on out_valid/dflt_valid/out_data after edge N, i.e. in cycle N+1. Minimum occupancy is 1 cycle.
- Throughput: 1 beat/cycle when the destination ready is held high.
- Back-pressure: while the addressed port's ready is low, in_ready=0 and the held beat is unchanged. No head-of-line bypass.
- Simultaneous drain and accept: the new beat replaces the buffer in the same edge with no bubble. This holds even when the destination changes.
- Reset mid-beat: a held, undelivered beat is discarded, and dflt_cnt clears.
- Counter saturation: at the maximum value, further default beats leave dflt_cnt unchanged.

## Test plan
- Reset and idle, OUTPUTS=4, WIDTH=8: during rst, all outputs are 0 and in_ready=0. After release, in_ready=1, out_valid=4'b0000, dflt_cnt=0.
- Streaming routing, all out_ready=1:
  - Stimulus: back-to-back beats data 0x11/0x22/0x33/0x44 with sel 0001/0010/0100/1000.
  - Response: out_valid is 0001,0010,0100,1000 on consecutive cycles, one cycle after each accept, with out_data matching; in_ready stays 1.
- Back-pressure:
  - Stimulus: send 0x5A to sel 0100 with out_ready[2]=0 for 3 cycles, and a second beat 0xA5 presented meanwhile.
  - Response: out_valid=0100 and out_data=0x5A held; in_ready=0 for 3 cycles. Once out_ready[2] rises, 0xA5 is accepted that same cycle, and ready on other ports has no effect.
- Default routing:
  - Stimulus: sel 0000 with data 0x01, then sel 0110 with data 0x02, dflt_ready=1.
  - Response: dflt_valid pulses twice, out_valid stays 0000, dflt_cnt ends at 2.
- Counter saturation and clear, CNT_WIDTH=2:
  - Stimulus: 5 default beats, then cnt_clr asserted in the same cycle as a 6th default accept.
  - Response: dflt_cnt goes 1,2,3,3,3, then 0.
- Async reset mid-operation:
  - Stimulus: assert rst while a beat is held with out_ready low.
  - Response: out_valid drops to 0 immediately without waiting for a clock, dflt_cnt=0, and no beat appears after release.

Source files
------------

// File: rtl/demux1hot_stream.sv
// One-hot stream demux: each beat goes to the port its select names; a select that is not exactly one-hot goes to the default port and is counted.
// Latency: 1 cycle through a single registered stage. A new beat can enter in the same cycle the held beat leaves, so it sustains 1 beat/cycle.
// Backpressure: in_ready is low while the held beat waits on its addressed port. Ready on the other ports is ignored.
module demux1hot_stream #(
    parameter int OUTPUTS   = 2,
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [OUTPUTS-1:0]   in_sel,
    output logic [OUTPUTS-1:0]   out_valid,
    input  logic [OUTPUTS-1:0]   out_ready,
    output logic                 dflt_valid,
    input  logic                 dflt_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] dflt_cnt,
    input  logic                 cnt_clr
);

    localparam logic [OUTPUTS-1:0]   SEL_ONE = {{(OUTPUTS-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic               buf_valid;
    logic [WIDTH-1:0]   buf_data;
    logic [OUTPUTS:0]   route;
    logic [OUTPUTS:0]   route_dec;
    logic               sel_onehot;
    logic               drained;
    logic               accept;

    // x & (x-1) clears the lowest set bit, so it is zero only when at most one bit is set
    assign sel_onehot = (in_sel != '0) && ((in_sel & (in_sel - SEL_ONE)) == '0);
    assign route_dec  = sel_onehot ? {1'b0, in_sel} : {1'b1, {OUTPUTS{1'b0}}};

    assign drained    = buf_valid & (|(route & {dflt_ready, out_ready}));
    assign in_ready   = ~rst & (~buf_valid | drained);
    assign accept     = in_valid & in_ready;

    assign out_valid  = {OUTPUTS{buf_valid}} & route[OUTPUTS-1:0];
    assign dflt_valid = buf_valid & route[OUTPUTS];
    assign out_data   = buf_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            route     <= '0;
        end else if (accept) begin
            buf_valid <= 1'b1;
            buf_data  <= in_data;
            route     <= route_dec;
        end else if (drained) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dflt_cnt <= '0;
        end else if (cnt_clr) begin
            dflt_cnt <= '0;
        end else if (accept && route_dec[OUTPUTS] && (dflt_cnt != CNT_MAX)) begin
            dflt_cnt <= dflt_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_demux1hot_stream.sv
module tb_demux1hot_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       dflt_valid;
    logic       dflt_ready;
    logic [7:0] out_data;
    logic [1:0] dflt_cnt;
    logic       cnt_clr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         port;
        logic [7:0] dat;
    } exp_t;
    exp_t sb[$];

    demux1hot_stream #(.OUTPUTS(4), .WIDTH(8), .CNT_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dflt_valid (dflt_valid),
        .dflt_ready (dflt_ready),
        .out_data   (out_data),
        .dflt_cnt   (dflt_cnt),
        .cnt_clr    (cnt_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int exp_port(input logic [3:0] s);
        int n = 0;
        int p = 4;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                n++;
                p = i;
            end
        end
        return (n == 1) ? p : 4;
    endfunction

    function automatic exp_t mk(input logic [3:0] s, input logic [7:0] d);
        exp_t e;
        e.port = exp_port(s);
        e.dat  = d;
        return e;
    endfunction

    // Output-side scoreboard: every handshake that the next edge will take must match the oldest beat sent.
    always @(negedge clk) begin
        if (!rst) begin
            int   fp;
            exp_t e;
            fp = -1;
            n_tests++;
            if ($countones({dflt_valid, out_valid}) > 1) begin
                n_fail++;
                $display("FAIL valid_onehot got %b want at most one bit", {dflt_valid, out_valid});
            end
            for (int i = 0; i < 4; i++)
                if (out_valid[i] && out_ready[i]) fp = i;
            if (dflt_valid && dflt_ready) fp = 4;
            if (fp >= 0) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected got port %0d data %h want no beat", fp, out_data);
                end else begin
                    e = sb.pop_front();
                    if (fp != e.port || out_data !== e.dat) begin
                        n_fail++;
                        $display("FAIL sb_beat got port %0d data %h want port %0d data %h",
                                 fp, out_data, e.port, e.dat);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 4'b0 || dflt_valid !== 1'b0 ||
            out_data !== 8'h00 || dflt_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold got rdy %b ov %b dv %b od %h cnt %0d want all 0",
                     in_ready, out_valid, dflt_valid, out_data, dflt_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0 || dflt_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release got rdy %b ov %b cnt %0d want 1 0000 0",
                     in_ready, out_valid, dflt_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0] s[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = d[k];
            in_sel   = s[k];
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d] got %b want 1", k, in_ready);
            end
            sb.push_back(mk(s[k], d[k]));
            @(posedge clk);
            #1;
            n_tests++;
            if (out_valid !== s[k] || out_data !== d[k]) begin
                n_fail++;
                $display("FAIL stream_out[%0d] got %b %h want %b %h", k, out_valid, out_data, s[k], d[k]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_sel    = 4'b0100;
        @(negedge clk);
        sb.push_back(mk(4'b0100, 8'h5A));
        @(posedge clk);
        #1;
        in_data = 8'hA5;
        in_sel  = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 4'b0100 || out_data !== 8'h5A) begin
                n_fail++;
                $display("FAIL bp_stall[%0d] got rdy %b ov %b od %h want 0 0100 5a",
                         k, in_ready, out_valid, out_data);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 4'b1111;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got rdy %b want 1", in_ready);
        end
        sb.push_back(mk(4'b0001, 8'hA5));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 4'b0001 || out_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL bp_next got %b %h want 0001 a5", out_valid, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_default();
        logic [3:0] s[2] = '{4'b0000, 4'b0110};
        logic [7:0] d[2] = '{8'h01, 8'h02};
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr    = 1'b0;
        dflt_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_sel   = s[k];
            in_data  = d[k];
            @(negedge clk);
            sb.push_back(mk(s[k], d[k]));
            @(posedge clk);
            #1;
            n_tests++;
            if (dflt_valid !== 1'b1 || out_valid !== 4'b0 || out_data !== d[k]) begin
                n_fail++;
                $display("FAIL dflt_out[%0d] got dv %b ov %b od %h want 1 0000 %h",
                         k, dflt_valid, out_valid, out_data, d[k]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (dflt_cnt !== 2'd2 || dflt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dflt_cnt got %0d dv %b want 2 0", dflt_cnt, dflt_valid);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            in_data = 8'hC0 + 8'(k);
            if (k == 5) cnt_clr = 1'b1;
            @(negedge clk);
            sb.push_back(mk(in_sel, in_data));
            @(posedge clk);
            #1;
            n_tests++;
            if (k < 5 && dflt_cnt !== want[k]) begin
                n_fail++;
                $display("FAIL sat_cnt[%0d] got %0d want %0d", k, dflt_cnt, want[k]);
            end else if (k == 5 && dflt_cnt !== 2'd0) begin
                n_fail++;
                $display("FAIL sat_clr got %0d want 0", dflt_cnt);
            end
        end
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_sel   = 4'b0000;
        in_data  = 8'hEE;
        @(negedge clk);
        sb.push_back(mk(4'b0000, 8'hEE));
        @(posedge clk);
        #1;
        out_ready = 4'b0000;
        in_sel    = 4'b0010;
        in_data   = 8'h77;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 4'b0010 || dflt_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL rmid_held got ov %b cnt %0d want 0010 1", out_valid, dflt_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 4'b0 || dflt_cnt !== 2'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async got ov %b cnt %0d rdy %b want 0000 0 0", out_valid, dflt_cnt, in_ready);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 4'b0 || dflt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_after[%0d] got ov %b dv %b want 0000 0", k, out_valid, dflt_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_sel     = 4'b0000;
        out_ready  = 4'b1111;
        dflt_ready = 1'b1;
        cnt_clr    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_default();
        test_saturate();
        test_reset_mid();
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
